// File: rtl/tid_pkg.sv
// Shared types and default geometry for the thread-ID loader and its RAM wrapper.
// Latency: n/a (declarations only). Backpressure: n/a.
package tid_pkg;

    typedef enum logic [1:0] {
        TID_IDLE = 2'd0,
        TID_LOAD = 2'd1,
        TID_DONE = 2'd2
    } tid_state_t;

    localparam int TID_DATA_WIDTH = 32;
    localparam int TID_ADDR_WIDTH = 10;

endpackage

// File: rtl/thread_id_loader.sv
// Launch-time writer of the thread-ID RAM: one ID per cycle, then a done pulse (2D mode: THREAD_ID_2D_EN).
// Latency: first write one cycle after start, done one cycle after the last write.
// Backpressure: none; the RAM always accepts, and start outside IDLE is dropped.
module thread_id_loader
    import tid_pkg::*;
#(
    parameter int DATA_WIDTH = TID_DATA_WIDTH,
    parameter int ADDR_WIDTH = TID_ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [DATA_WIDTH-1:0]   base_id,
    input  logic [DATA_WIDTH-1:0]   stride,
    input  logic [ADDR_WIDTH:0]     count,
`ifdef THREAD_ID_2D_EN
    input  logic [DATA_WIDTH/2-1:0] dim_x,
`endif
    output logic [ADDR_WIDTH-1:0]   wa,
    output logic                    we,
    output logic [DATA_WIDTH-1:0]   di,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_WIDTH:0]     loaded_count
);

    localparam int HALF = DATA_WIDTH / 2;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};

    tid_state_t            state_q, state_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic [ADDR_WIDTH:0]   count_clamped;
    logic                  last_write;
    logic [DATA_WIDTH-1:0] step_dat;

    logic [ADDR_WIDTH-1:0] wa_d;
    logic                  we_d;
    logic [DATA_WIDTH-1:0] di_d;
    logic                  busy_d;
    logic                  done_d;
    logic [ADDR_WIDTH:0]   loaded_count_d;

    assign count_clamped = (count > DEPTH_C) ? DEPTH_C : count;
    // wa doubles as the entry index; cnt_q is never 0 while in LOAD
    assign last_write    = ({1'b0, wa} == (cnt_q - 1'b1));

`ifdef THREAD_ID_2D_EN
    logic [HALF-1:0] dim_x_q, dim_x_d;
    logic [HALF-1:0] x_cur, y_cur, x_inc;

    assign x_cur = di[HALF-1:0];
    assign y_cur = di[DATA_WIDTH-1:HALF];
    assign x_inc = x_cur + 1'b1;
    assign step_dat = (x_inc == dim_x_q) ? {y_cur + 1'b1, {HALF{1'b0}}}
                                         : {y_cur, x_inc};
`else
    logic [DATA_WIDTH-1:0] stride_q, stride_d;

    assign step_dat = di + stride_q;
`endif

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        wa_d           = wa;
        we_d           = 1'b0;
        di_d           = di;
        busy_d         = busy;
        done_d         = 1'b0;
        loaded_count_d = loaded_count;
`ifdef THREAD_ID_2D_EN
        dim_x_d        = dim_x_q;
`else
        stride_d       = stride_q;
`endif

        case (state_q)
            TID_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    cnt_d  = count_clamped;
                    wa_d   = '0;
                    di_d   = base_id;
                    busy_d = 1'b1;
`ifdef THREAD_ID_2D_EN
                    dim_x_d = (dim_x == '0) ? HALF'(1) : dim_x;
`else
                    stride_d = stride;
`endif
                    if (count_clamped == '0) begin
                        state_d        = TID_DONE;
                        done_d         = 1'b1;
                        loaded_count_d = '0;
                    end else begin
                        state_d = TID_LOAD;
                        we_d    = 1'b1;
                    end
                end
            end
            TID_LOAD: begin
                if (last_write) begin
                    state_d        = TID_DONE;
                    done_d         = 1'b1;
                    loaded_count_d = cnt_q;
                end else begin
                    wa_d = wa + 1'b1;
                    di_d = step_dat;
                    we_d = 1'b1;
                end
            end
            TID_DONE: begin
                state_d = TID_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = TID_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= TID_IDLE;
            cnt_q        <= '0;
            wa           <= '0;
            we           <= 1'b0;
            di           <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            loaded_count <= '0;
`ifdef THREAD_ID_2D_EN
            dim_x_q      <= HALF'(1);
`else
            stride_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wa           <= wa_d;
            we           <= we_d;
            di           <= di_d;
            busy         <= busy_d;
            done         <= done_d;
            loaded_count <= loaded_count_d;
`ifdef THREAD_ID_2D_EN
            dim_x_q      <= dim_x_d;
`else
            stride_q     <= stride_d;
`endif
        end
    end

endmodule

// File: tb/tb_thread_id_loader.sv
// Directed bench for thread_id_loader; the 2D sequence is exercised when THREAD_ID_2D_EN is defined.
module tb_thread_id_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_id = '0;
    logic [31:0] stride = '0;
    logic [10:0] count = '0;
    logic [15:0] dim_x = '0;
    logic [9:0]  wa;
    logic        we;
    logic [31:0] di;
    logic        busy;
    logic        done;
    logic [10:0] loaded_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_di [0:1023];

    thread_id_loader dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .base_id      (base_id),
        .stride       (stride),
        .count        (count),
`ifdef THREAD_ID_2D_EN
        .dim_x        (dim_x),
`endif
        .wa           (wa),
        .we           (we),
        .di           (di),
        .busy         (busy),
        .done         (done),
        .loaded_count (loaded_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse start for one edge, then check every write cycle and the done cycle.
    task automatic run_launch(input string tag, input logic [31:0] b, input logic [31:0] s,
                              input logic [10:0] c, input logic [15:0] dx,
                              input int n, input bit check_di);
        @(negedge clk);
        base_id = b;
        stride  = s;
        count   = c;
        dim_x   = dx;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s_we%0d", tag, k), {63'd0, we}, 64'd1);
            chk($sformatf("%s_wa%0d", tag, k), {54'd0, wa}, 64'(k));
            if (check_di) chk($sformatf("%s_di%0d", tag, k), {32'd0, di}, {32'd0, exp_di[k]});
            if (k == 0) chk($sformatf("%s_busy_first", tag), {63'd0, busy}, 64'd1);
            @(negedge clk);
        end
        chk({tag, "_done"}, {63'd0, done}, 64'd1);
        chk({tag, "_busy_done"}, {63'd0, busy}, 64'd1);
        chk({tag, "_we_done"}, {63'd0, we}, 64'd0);
        chk({tag, "_loaded"}, {53'd0, loaded_count}, 64'(n));
        @(negedge clk);
        chk({tag, "_done_off"}, {63'd0, done}, 64'd0);
        chk({tag, "_busy_off"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_wa", {54'd0, wa}, 64'd0);
        chk("rst_we", {63'd0, we}, 64'd0);
        chk("rst_di", {32'd0, di}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_loaded", {53'd0, loaded_count}, 64'd0);
        rst = 1'b0;

`ifndef THREAD_ID_2D_EN
        exp_di[0] = 32'd100; exp_di[1] = 32'd104; exp_di[2] = 32'd108;
        exp_di[3] = 32'd112; exp_di[4] = 32'd116;
        run_launch("lin5", 32'd100, 32'd4, 11'd5, 16'd0, 5, 1'b1);

        exp_di[0] = 32'hFFFF_FFFE; exp_di[1] = 32'hFFFF_FFFF;
        exp_di[2] = 32'h0000_0000; exp_di[3] = 32'h0000_0001;
        run_launch("wrap", 32'hFFFF_FFFE, 32'd1, 11'd4, 16'd0, 4, 1'b1);
`else
        exp_di[0] = 32'h0000_0000; exp_di[1] = 32'h0000_0001; exp_di[2] = 32'h0000_0002;
        exp_di[3] = 32'h0001_0000; exp_di[4] = 32'h0001_0001; exp_di[5] = 32'h0001_0002;
        exp_di[6] = 32'h0002_0000;
        run_launch("xy7", 32'd0, 32'd99, 11'd7, 16'd3, 7, 1'b1);
`endif

        // Reset in the middle of a launch, with a second start pulsed during LOAD
        @(negedge clk);
        base_id = 32'd0; stride = 32'd1; count = 11'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b1;
        base_id = 32'd500; count = 11'd3;
        chk("mid_wa0", {54'd0, wa}, 64'd0);
        @(negedge clk);
        start = 1'b0;
        chk("mid_wa1", {54'd0, wa}, 64'd1);
        @(negedge clk);
        chk("mid_wa2", {54'd0, wa}, 64'd2);
        chk("mid_we2", {63'd0, we}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_we", {63'd0, we}, 64'd0);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_done", {63'd0, done}, 64'd0);
        chk("mid_rst_loaded", {53'd0, loaded_count}, 64'd0);
        @(negedge clk);
        chk("mid_idle_we", {63'd0, we}, 64'd0);

        // Oversized count clamps to full RAM depth
        for (int k = 0; k < 1024; k++) exp_di[k] = 32'd7 + 32'(k) * 32'd3;
`ifndef THREAD_ID_2D_EN
        run_launch("clamp", 32'd7, 32'd3, 11'd2000, 16'd0, 1024, 1'b1);
`else
        run_launch("clamp", 32'd7, 32'd3, 11'd2000, 16'd5, 1024, 1'b0);
`endif

        run_launch("zero", 32'd55, 32'd1, 11'd0, 16'd0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
